// File: rtl/ps2_keys_pkg.sv
// Shared scan-code constants, parser state and event bundle
// for the PS/2 direction decoder.
package ps2_keys_pkg;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;

   localparam logic [7:0] DEF_KEY_UP    = 8'h1D;
   localparam logic [7:0] DEF_KEY_DOWN  = 8'h1B;
   localparam logic [7:0] DEF_KEY_LEFT  = 8'h1C;
   localparam logic [7:0] DEF_KEY_RIGHT = 8'h23;
   localparam logic [7:0] DEF_ARW_UP    = 8'h75;
   localparam logic [7:0] DEF_ARW_DOWN  = 8'h72;
   localparam logic [7:0] DEF_ARW_LEFT  = 8'h6B;
   localparam logic [7:0] DEF_ARW_RIGHT = 8'h74;

   localparam int UP    = 0;
   localparam int DOWN  = 1;
   localparam int LEFT  = 2;
   localparam int RIGHT = 3;

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } pstate_e;

   typedef struct packed {
      logic       valid;
      logic       is_break;
      logic       is_ext;
      logic [7:0] code;
   } ps2_ev_t;

   // Fixed fallback order: up > down > left > right
   function automatic logic [3:0] prio_pick(input logic [3:0] h);
      logic [3:0] r;
      r = '0;
      if (h[UP])         r[UP]    = 1'b1;
      else if (h[DOWN])  r[DOWN]  = 1'b1;
      else if (h[LEFT])  r[LEFT]  = 1'b1;
      else if (h[RIGHT]) r[RIGHT] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/ps2_scancode_parser.sv
// Prefix parser: folds E0/F0 prefixes into a single-cycle
// key event and abandons stale prefixes after a timeout.
module ps2_scancode_parser
   import ps2_keys_pkg::*;
#(
   parameter int PREFIX_TIMEOUT = 2_500_000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       flush_i,
   input  logic [7:0] data_i,
   input  logic       en_i,
   output ps2_ev_t    ev_o
);

   localparam int CW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(PREFIX_TIMEOUT - 1);

   pstate_e       state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ev_o    = '0;
      if (en_i) begin
         cnt_d     = '0;
         ev_o.code = data_i;
         unique case (state_q)
            IDLE: begin
               if (data_i == SC_EXT)      state_d = EXT;
               else if (data_i == SC_BRK) state_d = BRK;
               else                       ev_o.valid = 1'b1;
            end
            EXT: begin
               if (data_i == SC_BRK) begin
                  state_d = EXT_BRK;
               end else begin
                  state_d     = IDLE;
                  ev_o.valid  = 1'b1;
                  ev_o.is_ext = 1'b1;
               end
            end
            BRK: begin
               state_d       = IDLE;
               ev_o.valid    = 1'b1;
               ev_o.is_break = 1'b1;
            end
            EXT_BRK: begin
               state_d       = IDLE;
               ev_o.valid    = 1'b1;
               ev_o.is_break = 1'b1;
               ev_o.is_ext   = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_direction_decoder.sv
// Keyboard direction decoder: held-key bitmap for letter and
// arrow key sets, last-pressed priority and one-hot outputs.
module ps2_direction_decoder
   import ps2_keys_pkg::*;
#(
   parameter logic [7:0] KEY_UP         = DEF_KEY_UP,
   parameter logic [7:0] KEY_DOWN       = DEF_KEY_DOWN,
   parameter logic [7:0] KEY_LEFT       = DEF_KEY_LEFT,
   parameter logic [7:0] KEY_RIGHT      = DEF_KEY_RIGHT,
   parameter logic [7:0] ARW_UP         = DEF_ARW_UP,
   parameter logic [7:0] ARW_DOWN       = DEF_ARW_DOWN,
   parameter logic [7:0] ARW_LEFT       = DEF_ARW_LEFT,
   parameter logic [7:0] ARW_RIGHT      = DEF_ARW_RIGHT,
   parameter int         STICKY         = 1,
   parameter int         PREFIX_TIMEOUT = 2_500_000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   input  logic       flush,
   output logic       goup,
   output logic       godown,
   output logic       goleft,
   output logic       goright,
   output logic       dir_change,
   output logic [3:0] key_held
);

   ps2_ev_t    ev;
   logic [3:0] key_hit, arw_hit, hit;
   logic [7:0] held_q, held_d;
   logic [3:0] go_q, go_d;
   logic [3:0] kh_q, kh_d;
   logic       chg_q, chg_d;

   ps2_scancode_parser #(
      .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
   ) u_parser (
      .clk_i  (CLOCK_50),
      .rst_ni (reset),
      .flush_i(flush),
      .data_i (received_data),
      .en_i   (received_data_en),
      .ev_o   (ev)
   );

   always_comb begin
      key_hit        = '0;
      key_hit[UP]    = (ev.code == KEY_UP);
      key_hit[DOWN]  = (ev.code == KEY_DOWN);
      key_hit[LEFT]  = (ev.code == KEY_LEFT);
      key_hit[RIGHT] = (ev.code == KEY_RIGHT);
      arw_hit        = '0;
      arw_hit[UP]    = (ev.code == ARW_UP);
      arw_hit[DOWN]  = (ev.code == ARW_DOWN);
      arw_hit[LEFT]  = (ev.code == ARW_LEFT);
      arw_hit[RIGHT] = (ev.code == ARW_RIGHT);
      hit = ev.valid ? (ev.is_ext ? arw_hit : key_hit) : 4'b0;
   end

   always_comb begin
      logic [3:0] any;
      held_d = held_q;
      go_d   = go_q;
      any    = '0;
      if (|hit) begin
         if (!ev.is_break) begin
            if (ev.is_ext) held_d[7:4] = held_q[7:4] | hit;
            else           held_d[3:0] = held_q[3:0] | hit;
            go_d = hit;
         end else begin
            if (ev.is_ext) held_d[7:4] = held_q[7:4] & ~hit;
            else           held_d[3:0] = held_q[3:0] & ~hit;
            any = held_d[7:4] | held_d[3:0];
            // Only re-select once the active direction is no longer held
            if ((any & go_q) == 4'b0) begin
               if (any != 4'b0)  go_d = prio_pick(any);
               else if (STICKY == 0) go_d = '0;
            end
         end
      end
      any  = held_d[7:4] | held_d[3:0];
      kh_d = {any[UP], any[DOWN], any[LEFT], any[RIGHT]};
      chg_d = (go_d != go_q);
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset || flush) begin
         held_q <= '0;
         go_q   <= '0;
         kh_q   <= '0;
         chg_q  <= 1'b0;
      end else begin
         held_q <= held_d;
         go_q   <= go_d;
         kh_q   <= kh_d;
         chg_q  <= chg_d;
      end
   end

   assign goup       = go_q[UP];
   assign godown     = go_q[DOWN];
   assign goleft     = go_q[LEFT];
   assign goright    = go_q[RIGHT];
   assign dir_change = chg_q;
   assign key_held   = kh_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench: a sticky and a non-sticky decoder share the
// same byte stream and are checked against hand-derived values.
module tb_ps2_direction_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data = 8'h00;
   logic       en = 1'b0;
   logic       fl = 1'b0;

   logic       s_up, s_dn, s_lf, s_rt, s_dc;
   logic       n_up, n_dn, n_lf, n_rt, n_dc;
   logic [3:0] s_kh, n_kh;
   logic [3:0] s_go, n_go;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ps2_direction_decoder #(.STICKY(1), .PREFIX_TIMEOUT(16)) dut_s (
      .CLOCK_50(clk), .reset(rst), .received_data(data),
      .received_data_en(en), .flush(fl),
      .goup(s_up), .godown(s_dn), .goleft(s_lf), .goright(s_rt),
      .dir_change(s_dc), .key_held(s_kh)
   );

   ps2_direction_decoder #(.STICKY(0), .PREFIX_TIMEOUT(16)) dut_n (
      .CLOCK_50(clk), .reset(rst), .received_data(data),
      .received_data_en(en), .flush(fl),
      .goup(n_up), .godown(n_dn), .goleft(n_lf), .goright(n_rt),
      .dir_change(n_dc), .key_held(n_kh)
   );

   assign s_go = {s_up, s_dn, s_lf, s_rt};
   assign n_go = {n_up, n_dn, n_lf, n_rt};

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      data = b;
      en   = 1'b1;
      @(negedge clk);
      en   = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge clk);
      fl = 1'b1;
      @(negedge clk);
      fl = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      chk("rst_s_go", s_go, 4'b0000);
      chk("rst_n_go", n_go, 4'b0000);
      chk("rst_s_kh", s_kh, 4'b0000);
      chk("rst_s_dc", {3'b0, s_dc}, 4'b0000);

      // reset in the middle of an E0 sequence
      send(8'hE0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      send(8'h75);
      chk("midrst_go", s_go, 4'b0000);
      chk("midrst_kh", s_kh, 4'b0000);

      // sticky vs non-sticky release
      send(8'h1D);
      chk("stk_press_go", s_go, 4'b1000);
      chk("stk_press_dc", {3'b0, s_dc}, 4'b0001);
      chk("stk_press_kh", s_kh, 4'b1000);
      @(negedge clk);
      chk("stk_dc_pulse", {3'b0, s_dc}, 4'b0000);
      send(8'hF0);
      chk("stk_prefix_go", s_go, 4'b1000);
      send(8'h1D);
      chk("stk_rel_go", s_go, 4'b1000);
      chk("stk_rel_dc", {3'b0, s_dc}, 4'b0000);
      chk("stk_rel_kh", s_kh, 4'b0000);
      chk("nstk_rel_go", n_go, 4'b0000);
      chk("nstk_rel_dc", {3'b0, n_dc}, 4'b0001);
      do_flush();

      // non-sticky fallback
      send(8'h1C);
      chk("fb_left", n_go, 4'b0010);
      chk("fb_left_dc", {3'b0, n_dc}, 4'b0001);
      send(8'h23);
      chk("fb_right", n_go, 4'b0001);
      chk("fb_right_dc", {3'b0, n_dc}, 4'b0001);
      send(8'hF0); send(8'h23);
      chk("fb_back_left", n_go, 4'b0010);
      chk("fb_back_dc", {3'b0, n_dc}, 4'b0001);
      send(8'hF0); send(8'h1C);
      chk("fb_none_n", n_go, 4'b0000);
      chk("fb_none_s", s_go, 4'b0010);
      chk("fb_none_kh", n_kh, 4'b0000);
      do_flush();

      // both key sets on the same direction
      send(8'h1D);
      send(8'hE0); send(8'h75);
      chk("mix_go", s_go, 4'b1000);
      chk("mix_dc", {3'b0, s_dc}, 4'b0000);
      send(8'hF0); send(8'h1D);
      chk("mix_rel1_go", n_go, 4'b1000);
      chk("mix_rel1_kh", n_kh, 4'b1000);
      chk("mix_rel1_dc", {3'b0, n_dc}, 4'b0000);
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("mix_rel2_kh", n_kh, 4'b0000);
      chk("mix_rel2_n", n_go, 4'b0000);
      chk("mix_rel2_s", s_go, 4'b1000);
      do_flush();

      // stale F0 abandoned after timeout
      send(8'hF0);
      repeat (20) @(negedge clk);
      send(8'h1B);
      chk("tmo_go", s_go, 4'b0100);
      chk("tmo_kh", s_kh, 4'b0100);
      do_flush();

      // letter behind E0 and arrow without E0 are ignored
      send(8'hE0); send(8'h1D);
      chk("unm_ext_go", s_go, 4'b0000);
      send(8'h75);
      chk("unm_arw_kh", s_kh, 4'b0000);
      send(8'hE1); send(8'h14); send(8'h77);
      chk("unm_e1_go", s_go, 4'b0000);
      send(8'h23);
      chk("unm_right", s_go, 4'b0001);
      do_flush();
      chk("flush_go", s_go, 4'b0000);
      chk("flush_kh", s_kh, 4'b0000);

      // priority fallback: up > down > left > right
      send(8'h1B); send(8'h23); send(8'h1D);
      chk("prio_up", n_go, 4'b1000);
      chk("prio_kh", n_kh, 4'b1101);
      send(8'hF0); send(8'h1D);
      chk("prio_down", n_go, 4'b0100);
      send(8'hF0); send(8'h1B);
      chk("prio_right", n_go, 4'b0001);

      // typematic repeat of a held key becomes latest press
      send(8'h1C);
      chk("typ_left", n_go, 4'b0010);
      send(8'h23);
      chk("typ_right", n_go, 4'b0001);
      send(8'h23);
      chk("typ_rep_dc", {3'b0, n_dc}, 4'b0000);
      send(8'h1C);
      chk("typ_rep_left", n_go, 4'b0010);

      // release of a key that is not held
      send(8'hF0); send(8'h1B);
      chk("rel_nohold", n_go, 4'b0010);

      // flush beats a byte in the same cycle
      do_flush();
      @(negedge clk);
      data = 8'h1D; en = 1'b1; fl = 1'b1;
      @(negedge clk);
      en = 1'b0; fl = 1'b0;
      chk("flush_pri_go", s_go, 4'b0000);
      chk("flush_pri_kh", s_kh, 4'b0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ps2_direction_decoder.md
Name: ps2_direction_decoder

Overview:
Second-generation keyboard-to-direction decoder for the Pacman game. It consumes the byte stream from PS2_Controller (received_data / received_data_en) and parses make, break (F0) and extended (E0) sequences. It tracks which of two key sets (letter keys and extended arrow keys) are held, and drives one-hot goup/godown/goleft/goright using last-pressed priority, a selectable sticky mode and a prefix timeout. It sits between PS2_Controller and the game movement logic.

Parameters:
KEY_UP, 8'h1D, non-extended make code for up (W)
KEY_DOWN, 8'h1B, non-extended make code for down (S)
KEY_LEFT, 8'h1C, non-extended make code for left (A)
KEY_RIGHT, 8'h23, non-extended make code for right (D)
ARW_UP / ARW_DOWN / ARW_LEFT / ARW_RIGHT, 8'h75 / 8'h72 / 8'h6B / 8'h74, extended (E0-prefixed) arrow codes
STICKY, 1, 1: hold last direction after all keys are released; 0: outputs go to zero when nothing is held
PREFIX_TIMEOUT, 2_500_000, number of CLOCK_50 cycles without a byte before a pending prefix is abandoned (at least 2)

Ports:
CLOCK_50  input  1  system clock; the only clock in the block
reset  input  1  synchronous, active-low reset
received_data  input  8  scan-code byte from PS2_Controller
received_data_en  input  1  single-cycle strobe: received_data is valid
flush  input  1  synchronous clear of held keys, outputs and parser (game restart)
goup / godown / goleft / goright  output  1 each  registered, one-hot or all zero
dir_change  output  1  one-cycle pulse when the direction outputs change value
key_held  output  4  registered {up,down,left,right}: direction held by either key set

Behaviour:
- Reset (reset==0 at a rising edge) clears all outputs, the held bitmap, the active direction, the timeout counter and the parser state (to IDLE). flush==1 has the same effect. reset has priority over flush; flush has priority over a byte arriving in the same cycle.
- Parser FSM. A transition happens only on a cycle with received_data_en==1.
  - IDLE: E0 -> EXT; F0 -> BRK; KEY_* -> press the matching direction, non-extended set; any other byte -> ignored, stay in IDLE.
  - EXT: F0 -> EXT_BRK; ARW_* -> press, arrow set, go to IDLE; any other byte (including E0) -> IDLE, ignored.
  - BRK: KEY_* -> release, non-extended set, go to IDLE; any other byte -> IDLE.
  - EXT_BRK: ARW_* -> release, arrow set, go to IDLE; any other byte -> IDLE.
  - A KEY_* code arriving in EXT is not a press, and an ARW_* code arriving in IDLE is not a press.
  - E1 (pause key) and the bytes that follow it fall through as unmapped and are ignored.
- Timeout. A counter runs while the FSM is not in IDLE and resets on every accepted byte. When it reaches PREFIX_TIMEOUT-1, the FSM returns to IDLE and the partial sequence is discarded; held keys are unchanged.
- Held bitmap: 8 bits (4 directions × 2 key sets). key_held[d] is the OR of the two sets for direction d.
  - A repeated make (typematic) for an already-held key sets nothing new but counts as the latest press.
  - Releasing a key that is not held is a no-op.
- Active direction:
  - On a press of direction d, active becomes d.
  - On a release that leaves the active direction's key_held bit clear: if any direction is still held, active becomes the highest-priority held one (up > down > left > right); otherwise STICKY=1 keeps active and STICKY=0 clears the outputs.
  - Releasing one set while the other set still holds the same direction does not change active.
- Latency: bitmap, active direction and outputs update at the rising edge that samples received_data_en==1, so they are visible the following cycle. dir_change is asserted in that same cycle, for one cycle, only if the go* vector differs from its previous value.
- Outputs are never multi-hot.

Decomposition:
- Package ps2_keys_pkg holds:
  - default scan-code constants;
  - the E0 and F0 prefix constants;
  - the parser state enum {IDLE, EXT, BRK, EXT_BRK};
  - direction index constants UP=0, DOWN=1, LEFT=2, RIGHT=3.
- Sub-module ps2_scancode_parser contains the FSM and timeout. It emits a single-cycle event {valid, is_break, is_ext, code}.
- The top level holds the bitmap, the priority logic and the output registers.

Test Plan:
- Reset mid-sequence: send E0, drive reset=0 for 1 cycle, then send 75 -> no press; outputs stay 0000.
- Sticky mode: with STICKY=1, send 1D, then F0 1D -> goup=1 one cycle after the first strobe with dir_change pulsed once; goup stays 1 after the break.
- Non-sticky fallback: with STICKY=0, send 1C, 23, then F0 23 -> outputs go left, then right (dir_change), then left again; after F0 1C the outputs are 0000.
- Mixed key sets: send 1D, then E0 75, then F0 1D -> goup stays 1 and key_held stays 4'b1000 with no dir_change; after E0 F0 75, key_held is 0000.
- Prefix timeout: with PREFIX_TIMEOUT=16, send F0, idle 20 cycles, then send 1B -> treated as a press, so godown=1.
- Unmapped and flush: send E0 1D (a letter code behind the extended prefix) -> ignored; send 23 then assert flush -> outputs 0000 and key_held 0000 on the next cycle.
